// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side blocks.
package fifo_pkg;

  localparam int unsigned FIFO_RD_LATENCY = 1;
  localparam int unsigned OUT_BUF_DEPTH   = 2;

  typedef logic [1:0] occ_t;

  // Wide enough for buffered words plus words in flight from the FIFO.
  localparam int unsigned CREDIT_W = $clog2(OUT_BUF_DEPTH + FIFO_RD_LATENCY + 1);
  typedef logic [CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer for the FIFO stream reader. The head register drives the
// stream directly, and the tail catches one word while the head is stalled.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_pop,
  input  logic                 i_clear,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  output occ_t                 o_occ
);

  occ_t                 occ, occ_nxt;
  logic [SIZE_DATA-1:0] head, head_nxt;
  logic [SIZE_DATA-1:0] tail, tail_nxt;

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    if (i_clear) begin
      occ_nxt = '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (occ == '0) head_nxt = i_data;
          else           tail_nxt = i_data;
          occ_nxt = occ + 2'd1;
        end
        2'b01: begin
          head_nxt = tail;
          occ_nxt  = occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming word goes behind whatever remains.
          if (occ == occ_t'(OUT_BUF_DEPTH)) begin
            head_nxt = tail;
            tail_nxt = i_data;
          end else begin
            head_nxt = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ     <= '0;
      head    <= '0;
      tail    <= '0;
      o_valid <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      o_valid <= (occ_nxt != '0);
    end
  end

  assign o_data = head;
  assign o_occ  = occ;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && !i_clear && occ == occ_t'(OUT_BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues reads against buffer credit
// and presents the returned words as a valid/ready stream at full throughput.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned SIZE_CNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [SIZE_CNT-1:0]  o_rd_count
);

  logic    infl;
  logic    pop;
  logic    push;
  occ_t    occ;
  credit_t credit;

  assign pop    = o_valid & i_ready;
  assign credit = credit_t'(occ) + credit_t'(infl) - credit_t'(pop);

  // Reset gating keeps the FIFO untouched while its own pointers are being cleared.
  assign o_fifo_rd_en = i_rst_n & ~i_fifo_empty & ~i_flush
                      & (credit < credit_t'(OUT_BUF_DEPTH));

  assign push = infl & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl       <= 1'b0;
      o_rd_count <= '0;
    end else begin
      infl <= o_fifo_rd_en & ~i_flush;
      if (pop) o_rd_count <= o_rd_count + 1'b1;
    end
  end

  fifo_rd_skid #(
    .SIZE_DATA(SIZE_DATA)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_fifo_data),
    .i_pop   (pop),
    .i_clear (i_flush),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_occ   (occ)
  );

endmodule
